// File: rtl/aes_word_adapter_pkg.sv
// Shared types and widths for the AES word adapter: FSM state enum and block-slot helper.
package aes_adapter_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned BLK_W         = 128;
   localparam int unsigned WORDS_PER_BLK = 4;
   localparam int unsigned IDX_W         = 2;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      LOAD    = 2'd1,
      WAIT    = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   // Word 0 lands in the most significant slot of the block.
   function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0]  blk,
                                                 input logic [IDX_W-1:0]  idx,
                                                 input logic [WORD_W-1:0] w);
      logic [BLK_W-1:0] r;
      r = blk;
      case (idx)
         2'd0:    r[127:96] = w;
         2'd1:    r[95:64]  = w;
         2'd2:    r[63:32]  = w;
         default: r[31:0]   = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_word_adapter_if.sv
// Word streams in/out plus the AES core load/done bus seen by the adapter.
interface aes_word_adapter_if;
   import aes_adapter_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic              core_ld;
   logic [BLK_W-1:0]  core_key;
   logic [BLK_W-1:0]  core_text_in;
   logic              core_done;
   logic [BLK_W-1:0]  core_text_out;

   modport master (
      input  in_valid, in_data, out_ready, core_done, core_text_out,
      output in_ready, out_valid, out_data, core_ld, core_key, core_text_in
   );

   modport slave (
      output in_valid, in_data, out_ready, core_done, core_text_out,
      input  in_ready, out_valid, out_data, core_ld, core_key, core_text_in
   );

endinterface

// File: rtl/aes_wait_timer.sv
// Watchdog for the core wait: cleared by start, flags timeout on the WAIT_MAX-th armed cycle.
module aes_wait_timer #(
   parameter int unsigned WAIT_MAX = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic done,
   output logic timeout
);

   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

   logic [CNT_W-1:0] cnt;
   logic             armed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (start) begin
         cnt   <= '0;
         armed <= 1'b1;
      end else if (armed) begin
         if (done || timeout) armed <= 1'b0;
         else                 cnt   <= cnt + CNT_W'(1);
      end
   end

   assign timeout = armed && (cnt == LAST);

endmodule

// File: rtl/aes_word_adapter.sv
// Packs 32-bit plaintext words into 128-bit AES blocks, runs the core with a watchdog,
// and unpacks the ciphertext back into 32-bit words.
module aes_word_adapter
   import aes_adapter_pkg::*;
#(
   parameter int unsigned WAIT_MAX  = 20,
   parameter int unsigned BLK_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_word_adapter_if.master   bus,
   input  logic                 key_we,
   input  logic [BLK_W-1:0]     key_in,
   input  logic                 err_clr,
   output logic                 err,
   output logic [BLK_CNT_W-1:0] blk_cnt
);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [BLK_W-1:0] blk_q;
   logic [BLK_W-1:0] key_q;
   logic [BLK_W-1:0] out_q;
   logic             ld_q;
   logic             out_valid_q;
   logic             tmr_start;
   logic             tmr_done;
   logic             tmr_timeout;
   logic             last_word;

   assign tmr_start = (state == LOAD);
   assign tmr_done  = (state == WAIT) && bus.core_done;
   assign last_word = (idx == IDX_W'(WORDS_PER_BLK - 1));

   aes_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (tmr_start),
      .done    (tmr_done),
      .timeout (tmr_timeout)
   );

   assign bus.in_ready     = (state == COLLECT);
   assign bus.core_ld      = ld_q;
   assign bus.core_key     = key_q;
   assign bus.core_text_in = blk_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = out_q[BLK_W-1 -: WORD_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= COLLECT;
         idx         <= '0;
         blk_q       <= '0;
         key_q       <= '0;
         out_q       <= '0;
         ld_q        <= 1'b0;
         out_valid_q <= 1'b0;
         err         <= 1'b0;
         blk_cnt     <= '0;
      end else begin
         ld_q <= 1'b0;

         // The core latches the key on ld, so it must not move while a block is in flight.
         if (key_we && (state == COLLECT || state == DRAIN)) key_q <= key_in;

         if (err_clr) err <= 1'b0;

         case (state)
            COLLECT: begin
               if (bus.in_valid && bus.in_ready) begin
                  blk_q <= put_word(blk_q, idx, bus.in_data);
                  idx   <= idx + IDX_W'(1);
                  if (last_word) begin
                     state <= LOAD;
                     ld_q  <= 1'b1;
                  end
               end
            end
            LOAD: state <= WAIT;
            WAIT: begin
               // A done arriving in the timeout cycle still counts as success.
               if (bus.core_done) begin
                  out_q       <= bus.core_text_out;
                  out_valid_q <= 1'b1;
                  state       <= DRAIN;
               end else if (tmr_timeout) begin
                  err   <= 1'b1;
                  blk_q <= '0;
                  state <= COLLECT;
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  out_q <= {out_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                  idx   <= idx + IDX_W'(1);
                  if (last_word) begin
                     out_valid_q <= 1'b0;
                     blk_cnt     <= blk_cnt + BLK_CNT_W'(1);
                     state       <= COLLECT;
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_word_adapter.sv
// Scoreboard bench for aes_word_adapter with a behavioural AES core stand-in.
module tb_aes_word_adapter;
   import aes_adapter_pkg::*;

   localparam int unsigned WAIT_MAX  = 20;
   localparam int unsigned BLK_CNT_W = 16;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2 = 128'hfedcba98765432100123456789abcdef;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 key_we;
   logic [BLK_W-1:0]     key_in;
   logic                 err_clr;
   logic                 err;
   logic [BLK_CNT_W-1:0] blk_cnt;

   always #5 clk = ~clk;

   aes_word_adapter_if bus ();

   aes_word_adapter #(.WAIT_MAX(WAIT_MAX), .BLK_CNT_W(BLK_CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .key_we  (key_we),
      .key_in  (key_in),
      .err_clr (err_clr),
      .err     (err),
      .blk_cnt (blk_cnt)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0]  exp_out_q[$];
   logic [255:0] exp_ld_q[$];

   int           done_delay = 3;
   bit           done_en    = 1'b1;
   int           stall_cfg  = 0;
   int           stub_cnt   = 0;
   logic [127:0] stub_res;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Known FIPS-197 vector for K1/P1, otherwise a cheap reversible stand-in.
   function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] t);
      if (k == K1 && t == P1) return C1;
      return t ^ {k[63:0], k[127:64]};
   endfunction

   function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
      return b[127 - 32*i -: 32];
   endfunction

   // AES core stand-in: answers done_delay cycles after the ld cycle.
   always @(negedge clk) begin
      logic [255:0] e;
      bus.core_done = 1'b0;
      if (rst) begin
         stub_cnt = 0;
         bus.core_text_out = '0;
      end else begin
         if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               bus.core_done     = 1'b1;
               bus.core_text_out = stub_res;
            end
         end
         if (bus.core_ld) begin
            if (exp_ld_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_ld: text %h", bus.core_text_in);
            end else begin
               e = exp_ld_q.pop_front();
               chk("ld_key", bus.core_key, e[255:128]);
               chk("ld_text", bus.core_text_in, e[127:0]);
            end
            stub_res = core_model(bus.core_key, bus.core_text_in);
            stub_cnt = done_en ? done_delay : 0;
         end
      end
   end

   // Output monitor: applies back-pressure and pops the scoreboard on each accepted word.
   bit          have_word  = 1'b0;
   int          stall_left = 0;
   logic [31:0] held;

   always @(negedge clk) begin
      if (rst || !bus.out_valid) begin
         bus.out_ready = 1'b0;
         have_word     = 1'b0;
      end else begin
         chk("in_ready_drain", bus.in_ready, 1'b0);
         if (!have_word) begin
            have_word  = 1'b1;
            held       = bus.out_data;
            stall_left = stall_cfg;
         end else begin
            chk("out_stable", bus.out_data, held);
         end
         if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
         end else begin
            bus.out_ready = 1'b1;
            have_word     = 1'b0;
            if (exp_out_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out: got %h", bus.out_data);
            end else begin
               chk("out_word", bus.out_data, exp_out_q.pop_front());
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] w);
      int t = 0;
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         total++; bad++;
         $display("FAIL send_timeout: word %h", w);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Ends in the cycle after the 4th transfer, where ld must be up.
   task automatic send_block(input logic [127:0] b);
      for (int i = 0; i < 4; i++) send_word(word_of(b, i));
      chk("ld_latency", bus.core_ld, 1'b1);
      chk("in_ready_load", bus.in_ready, 1'b0);
   endtask

   task automatic expect_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
      exp_ld_q.push_back({k, p});
      for (int i = 0; i < 4; i++) exp_out_q.push_back(word_of(c, i));
   endtask

   task automatic write_key(input logic [127:0] k);
      key_we = 1'b1;
      key_in = k;
      @(negedge clk);
      key_we = 1'b0;
   endtask

   task automatic wait_drained();
      int t = 0;
      while (!(exp_out_q.size() == 0 && bus.in_ready && !bus.out_valid) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         total++; bad++;
         $display("FAIL drain_timeout: pending %0d", exp_out_q.size());
      end
   endtask

   initial begin
      logic [127:0] p;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      key_we       = 1'b0;
      key_in       = '0;
      err_clr      = 1'b0;

      @(negedge clk);
      chk("rst_core_ld", bus.core_ld, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_err", err, 1'b0);
      chk("rst_blk_cnt", blk_cnt, '0);
      chk("rst_core_key", bus.core_key, '0);
      chk("rst_text_in", bus.core_text_in, '0);
      chk("rst_out_data", bus.out_data, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Known-answer block and done->out_valid latency.
      write_key(K1);
      expect_block(K1, P1, C1);
      done_delay = 3;
      send_block(P1);
      repeat (3) @(negedge clk);
      chk("text_in_hold", bus.core_text_in, P1);
      chk("out_valid_early", bus.out_valid, 1'b0);
      @(negedge clk);
      chk("out_valid_latency", bus.out_valid, 1'b1);
      wait_drained();
      chk("blk_cnt_t1", blk_cnt, 16'd1);

      // Core never answers: timeout, then clear.
      done_en = 1'b0;
      p = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      exp_ld_q.push_back({K1, p});
      send_block(p);
      repeat (WAIT_MAX) @(negedge clk);
      chk("err_not_yet", err, 1'b0);
      @(negedge clk);
      chk("err_timeout", err, 1'b1);
      chk("in_ready_after_to", bus.in_ready, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_cleared", err, 1'b0);
      chk("blk_cnt_t2", blk_cnt, 16'd1);
      done_en = 1'b1;

      // Downstream stalls five cycles per word.
      stall_cfg = 5;
      p = 128'hdeadbeefcafef00d1234567889abcdef;
      expect_block(K1, p, core_model(K1, p));
      send_block(p);
      wait_drained();
      stall_cfg = 0;
      chk("blk_cnt_t3", blk_cnt, 16'd2);

      // Key write while waiting is dropped; in COLLECT it takes effect.
      done_delay = 8;
      p = 128'h11111111222222223333333344444444;
      expect_block(K1, p, core_model(K1, p));
      send_block(p);
      @(negedge clk);
      key_we = 1'b1;
      key_in = K2;
      @(negedge clk);
      key_we = 1'b0;
      chk("key_held_in_wait", bus.core_key, K1);
      wait_drained();
      write_key(K2);
      done_delay = 3;
      p = 128'ha5a5a5a55a5a5a5a0000ffffffff0000;
      expect_block(K2, p, core_model(K2, p));
      send_block(p);
      wait_drained();
      chk("blk_cnt_t5", blk_cnt, 16'd4);

      // Done lands in the timeout cycle: result wins, no error.
      done_delay = WAIT_MAX;
      p = 128'h0badc0de0badc0de0badc0de0badc0de;
      expect_block(K2, p, core_model(K2, p));
      send_block(p);
      repeat (WAIT_MAX) @(negedge clk);
      chk("t6_out_valid_early", bus.out_valid, 1'b0);
      @(negedge clk);
      chk("t6_out_valid", bus.out_valid, 1'b1);
      chk("t6_err", err, 1'b0);
      wait_drained();
      chk("t6_err_after", err, 1'b0);
      chk("blk_cnt_t6", blk_cnt, 16'd5);

      // Reset with a half-collected block; only the new block may reach the core.
      done_delay = 3;
      send_word(32'hbad00001);
      send_word(32'hbad00002);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_blk_cnt", blk_cnt, '0);
      chk("rst2_in_ready", bus.in_ready, 1'b1);
      chk("rst2_text_in", bus.core_text_in, '0);
      rst = 1'b0;
      @(negedge clk);
      write_key(K1);
      p = 128'h76543210fedcba9813579bdf2468ace0;
      expect_block(K1, p, core_model(K1, p));
      send_block(p);
      wait_drained();
      chk("blk_cnt_t4", blk_cnt, 16'd1);
      chk("ld_queue_empty", 128'(exp_ld_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_word_adapter.md
AES_WORD_ADAPTER -- requirements
Module: aes_word_adapter

Interface
REQ-001 Parameter WAIT_MAX, default 20: maximum cycles to wait for core_done after core_ld.
REQ-002 Parameter BLK_CNT_W, default 16: width of the completed-block counter.
REQ-003 clk  input  1: single clock; all logic on posedge clk.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 in_valid / in_ready / in_data  input / output / input  1/1/32: upstream plaintext word handshake.
REQ-006 key_we / key_in  input / input  1/128: cipher key write.
REQ-007 core_ld / core_key / core_text_in  output  1/128/128: drive AES core ld, key and text_in.
REQ-008 core_done / core_text_out  input  1/128: AES core done and text_out.
REQ-009 out_valid / out_ready / out_data  output / input / output  1/1/32: downstream ciphertext word handshake.
REQ-010 err / err_clr  output / input  1/1: sticky timeout flag and its clear.
REQ-011 blk_cnt  output  BLK_CNT_W: count of blocks fully drained.

Function
REQ-012 The FSM SHALL have exactly four states: COLLECT, LOAD, WAIT, DRAIN.
REQ-013 A transfer SHALL occur only in a cycle where valid and ready are both high.
REQ-014 COLLECT: in_ready=1; transfers fill the 128-bit block register in order, first word -> [127:96], last word -> [31:0]; a 2-bit word index SHALL count 0..3.
REQ-015 On the 4th COLLECT transfer the FSM SHALL move to LOAD; the word index wraps to 0.
REQ-016 LOAD SHALL last exactly one cycle with core_ld=1; the FSM then moves to WAIT.
REQ-017 core_ld SHALL be 0 in every state except LOAD.
REQ-018 core_text_in SHALL hold the assembled block, stable from LOAD until leaving WAIT.
REQ-019 WAIT: a watchdog counter starts at 0 on entry and increments each cycle.
REQ-020 On core_done=1 in WAIT, core_text_out SHALL be captured into the output register and the FSM SHALL move to DRAIN.
REQ-021 If the watchdog reaches WAIT_MAX without core_done, err SHALL be set, the block discarded, and the FSM SHALL return to COLLECT.
REQ-022 If core_done and timeout occur in the same cycle, core_done SHALL win and err SHALL stay unchanged.
REQ-023 core_done outside WAIT SHALL be ignored.
REQ-024 DRAIN: out_valid=1; words are emitted [127:96] first; out_data SHALL stay stable while out_ready=0.
REQ-025 After the 4th DRAIN transfer: blk_cnt increments (wrapping at 2^BLK_CNT_W), and the FSM returns to COLLECT.
REQ-026 in_ready SHALL be 0 in LOAD, WAIT and DRAIN; out_valid SHALL be 0 outside DRAIN.
REQ-027 key_we SHALL update core_key only in COLLECT or DRAIN; in LOAD and WAIT it is ignored.
REQ-028 Latency: 4th input transfer at cycle N -> core_ld=1 at N+1; core_done at cycle D -> out_valid=1 at D+1.
REQ-029 err_clr=1 SHALL clear err next cycle; if err_clr coincides with a new timeout, err SHALL be set.

Reset
REQ-030 On rst: state=COLLECT, word index=0, watchdog=0, blk_cnt=0, err=0, core_ld=0, in_ready=1 (combinational from state), out_valid=0, and core_key, core_text_in and out_data all 0.
REQ-031 rst mid-operation SHALL abort any partial block and in-flight encryption with no output produced.

Structure
REQ-032 Package aes_adapter_pkg SHALL hold the state enum, WORD_W=32, BLK_W=128 and WORDS_PER_BLK=4.
REQ-033 The watchdog SHALL be a sub-module aes_wait_timer (start, done, timeout inputs/outputs, WAIT_MAX parameter).

Verification
REQ-034 Test 1: key 000102030405060708090a0b0c0d0e0f, words 00112233 44556677 8899aabb ccddeeff with a real core -> out words 69c4e0d8 6a7b0430 d8cdb780 70b4c55a; blk_cnt=1.
REQ-035 Test 2: core_done never asserted -> err=1 exactly WAIT_MAX cycles after WAIT entry; FSM back in COLLECT with in_ready=1; err_clr -> err=0.
REQ-036 Test 3: out_ready low 5 cycles per word in DRAIN -> out_data stable; in_ready=0 throughout; order unchanged.
REQ-037 Test 4: rst after 2 words collected, then 4 new words -> only the new block encrypted; blk_cnt=1.
REQ-038 Test 5: key_we during WAIT -> core_key unchanged; key_we in COLLECT -> new key used for the next block.
REQ-039 Test 6: core_done on the cycle the watchdog hits WAIT_MAX -> result drained, err=0.
